lfsr_stream: RTL and testbench
==============================

// Module: lfsr_stream
// PURPOSE
//  Parametrised pseudo-random generator: WIDTH-bit LFSR, Fibonacci or Galois form, XOR or XNOR feedback.
//  Advances STEPS single-bit shifts per accepted transfer and presents its state on a valid/ready stream.
//  Supports runtime seed load, lock-state protection and a period-wrap strobe.
//  Feeds test-pattern generators, scramblers and BIST stimulus in the playground HW designs.
// PARAMETERS
//  WIDTH  8      LFSR length, 3..32
//  TAPS   8'hB8  feedback mask, bit i = state[i] participates (Fibonacci); Galois use below
//  MODE   0      0 = Fibonacci, 1 = Galois
//  XNOR   0      1 = inverted feedback; only legal with MODE=0 (elaboration error otherwise)
//  STEPS  1      single shifts per transfer, 1..WIDTH
//  SEED   8'h01  reset/recovery state; must not equal LOCK (elaboration error)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  reset      in   1      synchronous, active-high
//  en         in   1      request generation; sampled only when !out_valid || out_ready
//  seed_load  in   1      load seed_val this cycle (flush)
//  seed_val   in   WIDTH  seed value for seed_load
//  out_valid  out  1      out_data holds a valid word
//  out_ready  in   1      consumer accepts word
//  out_data   out  WIDTH  current LFSR state
//  wrap       out  1      1-cycle pulse: state has returned to ref seed
//  lock_err   out  1      1-cycle pulse: seed_val was LOCK and was replaced
// BEHAVIOUR
//  LOCK = all-zeros if XNOR=0, all-ones if XNOR=1.
//  Single step, Fibonacci: fb = (^(state & TAPS)) ^ XNOR; next = {state[W-2:0], fb}.
//  Single step, Galois: fb = state[W-1]; next = {state[W-2:0], fb} ^ ({W{fb}} & {TAPS[W-2:0],1'b0}).
//  Transfer: out_valid && out_ready. On transfer: state <= STEPS single steps applied, combinationally in one cycle.
//  Registers: state, ref_seed, out_valid, wrap, lock_err.
//  Reset (synchronous, priority 1):
//    state = SEED, ref_seed = SEED, out_valid = 0, wrap = 0, lock_err = 0.
//  seed_load (priority 2): state = ref_seed = (seed_val==LOCK ? SEED : seed_val); out_valid = 0; no transfer this cycle.
//    Aborts a pending word even if out_valid && !out_ready (sole exception to hold rule).
//    lock_err = 1 next cycle iff seed_val==LOCK.
//  Otherwise (priority 3):
//    if (!out_valid || out_ready) out_valid <= en; state advances only on transfer.
//  Hold rule: while out_valid && !out_ready, out_data and out_valid stay stable regardless of en.
//  Latency: en high at cycle N (idle) -> out_valid at N+1 with out_data = current state (no advance on first word).
//  Throughput: one word per cycle with out_ready held high.
//  wrap: registered; 1 in the cycle after a transfer whose next state == ref_seed; else 0.
//  LOCK is unreachable by stepping from a non-LOCK state for valid TAPS; no runtime recovery beyond load.
//  out_data = state at all times (also when out_valid=0).
// TESTING
//  T1 default params: reset, en=1, ready=1 -> out_data 01,02,04,08,11,23; wrap after 255 transfers, data=01.
//  T2 STEPS=4: from 0x01 one transfer -> 0x11; next transfer -> 0x11 advanced 4 more steps (check vs model).
//  T3 XNOR=1, TAPS=8'h88, seed_load 0x00 -> sequence 00,01,03,07,0F,1E; wrap after full period.
//  T4 seed_load 0x00 (XNOR=0) -> state=0x01, lock_err pulse 1 cycle, out_valid=0 that cycle.
//  T5 MODE=1 Galois, load 0x80, one transfer -> 0x71; ready low 5 cycles -> data/valid held stable.
//  T6 reset or seed_load asserted mid-stream with out_valid && !ready -> valid drops next cycle.
//    Post-load state = loaded value; random ready/en soak vs reference model, no word skipped or duplicated.

Source files
------------

// File: rtl/lfsr_stream.sv
// lfsr_stream: WIDTH-bit Fibonacci/Galois LFSR behind a valid/ready stream,
// with runtime seed load, lock-state substitution and a period-wrap strobe.
module lfsr_stream #(
   parameter int          WIDTH = 8,
   parameter logic [31:0] TAPS  = 32'h0000_00B8,
   parameter int          MODE  = 0,
   parameter int          XNOR  = 0,
   parameter int          STEPS = 1,
   parameter logic [31:0] SEED  = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_val,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             wrap,
   output logic             lock_err
);

   localparam logic             XNOR_B = (XNOR != 0);
   localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LOCK   = {WIDTH{XNOR_B}};

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_stream: WIDTH must be 3..32");
   end
   if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_stream: STEPS must be 1..WIDTH");
   end
   if (XNOR != 0 && MODE != 0) begin : g_bad_xnor
      $error("lfsr_stream: XNOR feedback needs Fibonacci mode");
   end
   if (SEED_W == LOCK) begin : g_bad_seed
      $error("lfsr_stream: SEED equals the lock state");
   end

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] ref_seed;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] load_val;
   logic             seed_is_lock;
   logic             xfer;

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
      logic fb;
      logic [WIDTH-1:0] r;
      if (MODE == 0) begin
         fb = (^(s & TAPS_W)) ^ XNOR_B;
         r  = {s[WIDTH-2:0], fb};
      end else begin
         fb = s[WIDTH-1];
         r  = {s[WIDTH-2:0], fb} ^ ({WIDTH{fb}} & {TAPS_W[WIDTH-2:0], 1'b0});
      end
      return r;
   endfunction

   // all STEPS shifts unrolled into one combinational cycle
   always_comb begin
      nxt = state;
      for (int i = 0; i < STEPS; i++) begin
         nxt = step1(nxt);
      end
   end

   assign seed_is_lock = (seed_val == LOCK);
   assign load_val     = seed_is_lock ? SEED_W : seed_val;
   assign xfer         = out_valid && out_ready;
   assign out_data     = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SEED_W;
         ref_seed  <= SEED_W;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         lock_err  <= 1'b0;
      end else if (seed_load) begin
         state     <= load_val;
         ref_seed  <= load_val;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
         lock_err  <= seed_is_lock;
      end else begin
         lock_err <= 1'b0;
         wrap     <= xfer && (nxt == ref_seed);
         if (xfer) begin
            state <= nxt;
         end
         if (!out_valid || out_ready) begin
            out_valid <= en;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: four lfsr_stream configurations run side by side against
// an arithmetic reference model, with directed steps and a random soak.
module tb_lfsr_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic       en        [4];
   logic       seed_load [4];
   logic [7:0] seed_val  [4];
   logic       out_ready [4];
   logic       out_valid [4];
   logic [7:0] out_data  [4];
   logic       wrap      [4];
   logic       lock_err  [4];

   int         steps_c [4] = '{1, 4, 1, 1};
   int         mode_c  [4] = '{0, 0, 0, 1};
   int         xnor_c  [4] = '{0, 0, 1, 0};
   logic [7:0] taps_c  [4] = '{8'hB8, 8'hB8, 8'h88, 8'hB8};

   logic [7:0] m_state [4];
   logic [7:0] m_ref   [4];
   logic       m_valid [4];
   logic       m_wrap  [4];
   logic       m_lerr  [4];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lfsr_stream u0 (
      .clk(clk), .reset(reset), .en(en[0]), .seed_load(seed_load[0]),
      .seed_val(seed_val[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]),
      .wrap(wrap[0]), .lock_err(lock_err[0])
   );

   lfsr_stream #(.STEPS(4)) u1 (
      .clk(clk), .reset(reset), .en(en[1]), .seed_load(seed_load[1]),
      .seed_val(seed_val[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]),
      .wrap(wrap[1]), .lock_err(lock_err[1])
   );

   lfsr_stream #(.XNOR(1), .TAPS(32'h88)) u2 (
      .clk(clk), .reset(reset), .en(en[2]), .seed_load(seed_load[2]),
      .seed_val(seed_val[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .out_data(out_data[2]),
      .wrap(wrap[2]), .lock_err(lock_err[2])
   );

   lfsr_stream #(.MODE(1)) u3 (
      .clk(clk), .reset(reset), .en(en[3]), .seed_load(seed_load[3]),
      .seed_val(seed_val[3]), .out_valid(out_valid[3]),
      .out_ready(out_ready[3]), .out_data(out_data[3]),
      .wrap(wrap[3]), .lock_err(lock_err[3])
   );

   // one shift of the polynomial written as arithmetic on the integer value
   function automatic logic [7:0] mstep(int c, logic [7:0] s);
      int v;
      int par;
      v = (int'(s) * 2) % 256;
      if (mode_c[c] == 0) begin
         par = ($countones(s & taps_c[c]) + xnor_c[c]) % 2;
         v   = v + par;
      end else if (s >= 8'h80) begin
         v = (v + 1) ^ ((int'(taps_c[c]) * 2) % 256);
      end
      return 8'(v);
   endfunction

   function automatic logic [7:0] lock_of(int c);
      return (xnor_c[c] != 0) ? 8'hFF : 8'h00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [7:0] nx;
      logic       xfer;
      for (int c = 0; c < 4; c++) begin
         if (reset) begin
            m_state[c] = 8'h01;
            m_ref[c]   = 8'h01;
            m_valid[c] = 1'b0;
            m_wrap[c]  = 1'b0;
            m_lerr[c]  = 1'b0;
         end else if (seed_load[c]) begin
            m_lerr[c]  = (seed_val[c] == lock_of(c));
            m_state[c] = m_lerr[c] ? 8'h01 : seed_val[c];
            m_ref[c]   = m_state[c];
            m_valid[c] = 1'b0;
            m_wrap[c]  = 1'b0;
         end else begin
            xfer = m_valid[c] && out_ready[c];
            nx   = m_state[c];
            for (int k = 0; k < steps_c[c]; k++) nx = mstep(c, nx);
            m_lerr[c] = 1'b0;
            m_wrap[c] = xfer && (nx == m_ref[c]);
            if (xfer) m_state[c] = nx;
            if (!m_valid[c] || out_ready[c]) m_valid[c] = en[c];
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("i%0d_valid", c), 32'(out_valid[c]), 32'(m_valid[c]));
         chk($sformatf("i%0d_data", c), 32'(out_data[c]), 32'(m_state[c]));
         chk($sformatf("i%0d_wrap", c), 32'(wrap[c]), 32'(m_wrap[c]));
         chk($sformatf("i%0d_lock_err", c), 32'(lock_err[c]), 32'(m_lerr[c]));
      end
   endtask

   logic [7:0] t1_seq [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
   logic [7:0] t3_seq [6] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E};

   initial begin
      int         ntr;
      int         period;
      logic [7:0] s;
      logic [7:0] lv;

      // reset state
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         en[c] = 1'b0; seed_load[c] = 1'b0;
         seed_val[c] = 8'h00; out_ready[c] = 1'b0;
      end
      tick();
      tick();
      chk("rst_data", 32'(out_data[0]), 32'h01);
      chk("rst_valid", 32'(out_valid[0]), 32'h0);

      // T1/T2: free run, first word is the seed itself
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         en[c] = 1'b1; out_ready[c] = 1'b1;
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t1_seq%0d", i), 32'(out_data[0]), 32'(t1_seq[i]));
         if (i == 1) chk("t2_first", 32'(out_data[1]), 32'h11);
      end
      ntr = 5;
      for (int i = 0; i < 300; i++) begin
         tick();
         ntr++;
         if (wrap[0]) break;
      end
      chk("t1_wrap_count", 32'(ntr), 32'd255);
      chk("t1_wrap_data", 32'(out_data[0]), 32'h01);

      // T4: loading the lock value substitutes SEED
      seed_load[0] = 1'b1; seed_val[0] = 8'h00;
      tick();
      chk("t4_lock_err", 32'(lock_err[0]), 32'h1);
      chk("t4_valid", 32'(out_valid[0]), 32'h0);
      chk("t4_data", 32'(out_data[0]), 32'h01);
      seed_load[0] = 1'b0;
      tick();
      chk("t4_lock_err_clr", 32'(lock_err[0]), 32'h0);

      // T3: XNOR feedback from the all-zeros state
      seed_load[2] = 1'b1; seed_val[2] = 8'h00;
      tick();
      seed_load[2] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("t3_seq%0d", i), 32'(out_data[2]), 32'(t3_seq[i]));
      end
      period = 1;
      s = mstep(2, 8'h00);
      while (s != 8'h00 && period < 300) begin
         s = mstep(2, s);
         period++;
      end
      ntr = 5;
      for (int i = 0; i < 300; i++) begin
         tick();
         ntr++;
         if (wrap[2]) break;
      end
      chk("t3_wrap_count", 32'(ntr), 32'(period));
      chk("t3_wrap_data", 32'(out_data[2]), 32'h00);

      // T5: Galois step, then backpressure hold
      seed_load[3] = 1'b1; seed_val[3] = 8'h80;
      tick();
      seed_load[3] = 1'b0;
      tick();
      chk("t5_first", 32'(out_data[3]), 32'h80);
      tick();
      chk("t5_step", 32'(out_data[3]), 32'h71);
      out_ready[3] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en[3] = 1'($urandom_range(0, 1));
         tick();
         chk("t5_hold_data", 32'(out_data[3]), 32'h71);
         chk("t5_hold_valid", 32'(out_valid[3]), 32'h1);
      end

      // T6: load aborts a stalled word
      lv = 8'($urandom_range(1, 254));
      seed_load[3] = 1'b1; seed_val[3] = lv;
      tick();
      chk("t6_load_valid", 32'(out_valid[3]), 32'h0);
      chk("t6_load_data", 32'(out_data[3]), 32'(lv));
      seed_load[3] = 1'b0; en[3] = 1'b1;
      tick();
      // T6: reset aborts stalled words everywhere
      for (int c = 0; c < 4; c++) out_ready[c] = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("t6_rst_valid", 32'(out_valid[0]), 32'h0);
      reset = 1'b0;

      // random soak
      for (int n = 0; n < 2000; n++) begin
         reset = ($urandom_range(0, 499) == 0);
         for (int c = 0; c < 4; c++) begin
            en[c]        = ($urandom_range(0, 3) != 0);
            out_ready[c] = 1'($urandom_range(0, 1));
            seed_load[c] = ($urandom_range(0, 59) == 0);
            case ($urandom_range(0, 3))
               0:       seed_val[c] = 8'h00;
               1:       seed_val[c] = 8'hFF;
               default: seed_val[c] = 8'($urandom);
            endcase
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
